// File: rtl/q2_mem.sv
// q2_mem: target memory for the Q2 strobe bus (abus/dbus/wrm/rdm), with a loader port.
// Strobes are synchronised into clk; reads drive dbus READ_LATENCY cycles after the rise is acted on.
module q2_mem #(
    parameter int WIDTH        = 12,
    parameter int ADDR_BITS    = 12,
    parameter int READ_LATENCY = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [11:0]          abus,
    inout  wire  [WIDTH-1:0]     dbus,
    input  logic                 wrm,
    input  logic                 rdm,
    input  logic                 ld_valid,
    input  logic [ADDR_BITS-1:0] ld_addr,
    input  logic [WIDTH-1:0]     ld_data,
    output logic                 ld_ready,
    output logic                 busy,
    output logic                 err,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_DRIVE = 3'd2,
        WR_HOLD  = 3'd3,
        ERR_HOLD = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   err_q, err_d;
    logic [SYNC_STAGES-1:0] wr_sync_q, rd_sync_q;
    logic                   s_wr_prev_q, s_rd_prev_q;
    logic                   s_wr, s_rd, wr_rise, rd_rise;

    logic [WIDTH-1:0]       mem_q [2**ADDR_BITS];
    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_waddr;
    logic [WIDTH-1:0]       mem_wdata;

    assign s_wr    = wr_sync_q[SYNC_STAGES-1];
    assign s_rd    = rd_sync_q[SYNC_STAGES-1];
    assign wr_rise = s_wr & ~s_wr_prev_q;
    assign rd_rise = s_rd & ~s_rd_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            wr_sync_q   <= '0;
            rd_sync_q   <= '0;
            s_wr_prev_q <= 1'b0;
            s_rd_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], wrm};
            rd_sync_q   <= {rd_sync_q[SYNC_STAGES-2:0], rdm};
            s_wr_prev_q <= s_wr;
            s_rd_prev_q <= s_rd;
        end
    end

    // Loader handshake: a word transfers at the clk edge where ld_valid & ld_ready;
    // the host holds ld_valid/ld_addr/ld_data steady until that edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = ld_addr;
        mem_wdata = ld_data;
        ld_ready  = rst & (state_q == IDLE) & ~s_rd & ~s_wr;

        case (state_q)
            IDLE: begin
                if ((rd_rise | wr_rise) & s_rd & s_wr) begin
                    err_d   = 1'b1;
                    state_d = ERR_HOLD;
                end else if (rd_rise) begin
                    addr_d  = abus[ADDR_BITS-1:0];
                    cnt_d   = 4'(READ_LATENCY - 1);
                    state_d = RD_WAIT;
                end else if (wr_rise) begin
                    // The single write of this strobe commits here; later dbus changes are ignored.
                    addr_d    = abus[ADDR_BITS-1:0];
                    mem_we    = 1'b1;
                    mem_waddr = abus[ADDR_BITS-1:0];
                    mem_wdata = dbus;
                    state_d   = WR_HOLD;
                end else if (ld_valid & ld_ready) begin
                    mem_we = 1'b1;
                end
            end
            RD_WAIT: begin
                if (wr_rise) begin
                    err_d   = 1'b1;
                    state_d = ERR_HOLD;
                end else if (!s_rd) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = RD_DRIVE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_DRIVE: begin
                if (wr_rise) begin
                    err_d   = 1'b1;
                    state_d = ERR_HOLD;
                end else if (!s_rd) begin
                    state_d = IDLE;
                end
            end
            WR_HOLD: begin
                if (rd_rise) begin
                    err_d   = 1'b1;
                    state_d = ERR_HOLD;
                end else if (!s_wr) begin
                    state_d = IDLE;
                end
            end
            ERR_HOLD: begin
                if (!s_wr && !s_rd) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Array is deliberately not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign dbus      = (state_q == RD_DRIVE) ? mem_q[addr_q] : {WIDTH{1'bz}};
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: doc/q2_mem.md
Name: q2_mem

Overview:
- Memory responder for the Q2 processor bus: the target end of the CPU's `abus`/`dbus`/`wrm`/`rdm` strobe interface.
- Holds a 2^ADDR_BITS x WIDTH word array.
- Synchronises the CPU's asynchronous strobes into its own clock, captures writes, and drives read data onto the shared `dbus` after a programmable latency.
- Provides a valid/ready loader port so a host or testbench can deposit a program while the bus is idle.

Parameters:
- WIDTH, 12, data word width; must match the `dbus` width.
- ADDR_BITS, 12, number of address bits used; range 1..12; the array holds 2^ADDR_BITS words.
- READ_LATENCY, 2, cycles from detected `rdm` rise to `dbus` drive; range 1..15.
- SYNC_STAGES, 2, flop stages in each strobe synchroniser; range 2..3.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- abus  input  12  address from CPU; only the low ADDR_BITS bits are used.
- dbus  inout  WIDTH  shared data bus; driven only in RD_DRIVE, otherwise hi-Z.
- wrm  input  1  write strobe, active-high, asynchronous to clk.
- rdm  input  1  read strobe, active-high, asynchronous to clk.
- ld_valid  input  1  loader word valid.
- ld_addr  input  ADDR_BITS  loader address.
- ld_data  input  WIDTH  loader data.
- ld_ready  output  1  loader accept; a transfer occurs on `ld_valid & ld_ready` at the clk edge.
- busy  output  1  high whenever the state is not IDLE.
- err  output  1  sticky strobe-collision flag.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - state = IDLE, latency counter = 0, synchroniser flops = 0.
  - `dbus` goes hi-Z immediately; `busy`=0, `err`=0, `ld_ready`=0 while in reset.
  - Array contents are not reset.
- Strobe handling:
  - `wrm` and `rdm` each pass through SYNC_STAGES flops; `s_wr`/`s_rd` are the synchronised levels.
  - A rise is sync output 1 with the previous value 0; at most one rise per strobe assertion.
  - The bus contract requires `abus`/`dbus` to be stable from SYNC_STAGES+1 cycles before a strobe rises until it falls.
  - The address is captured into `addr_q` on the rise-detect cycle.
- States: IDLE, RD_WAIT, RD_DRIVE, WR_HOLD, ERR_HOLD.
- IDLE:
  - `s_rd` rise with `s_wr`=0 -> RD_WAIT; counter loads READ_LATENCY-1.
  - `s_wr` rise with `s_rd`=0 -> `mem[abus]` <= `dbus` in that same cycle; -> WR_HOLD.
  - Both strobes rise in the same cycle -> `err`<=1, no access, -> ERR_HOLD.
- RD_WAIT:
  - Counter decrements each cycle; when it reaches 0 -> RD_DRIVE.
  - With READ_LATENCY=1 the state goes straight to RD_DRIVE on the next edge.
  - `s_rd` falls -> IDLE; `dbus` is never driven (aborted read).
  - `s_wr` rises -> `err`<=1, -> ERR_HOLD.
- RD_DRIVE:
  - `dbus` = `mem[addr_q]`; the first drive occurs READ_LATENCY cycles after the rise-detect edge.
  - Drive is held while `s_rd`=1; `s_rd`=0 -> IDLE and `dbus` is hi-Z from that edge.
  - `s_wr` rises -> `err`<=1, drive released, -> ERR_HOLD.
- WR_HOLD:
  - Exactly one write per strobe; further changes on `dbus` are ignored.
  - `s_wr`=0 -> IDLE.
  - `s_rd` rises -> `err`<=1, -> ERR_HOLD; the completed write stands.
- ERR_HOLD:
  - No access and `dbus` hi-Z; -> IDLE once `s_wr`=0 and `s_rd`=0.
  - `err` stays set until reset.
- Loader:
  - `ld_ready` = (state==IDLE) & ~`s_rd` & ~`s_wr` (combinational).
  - On `ld_valid & ld_ready`, `mem[ld_addr]` <= `ld_data`.
  - A strobe rise in the same cycle wins because `ld_ready` is already 0; the loader must hold `ld_valid` and `ld_data` until accepted.
- `busy` = (state != IDLE), registered via state.
- Address aliasing: `abus` bits above ADDR_BITS are ignored, so address 0x800 aliases 0x000 when ADDR_BITS=11.
- Reset mid-operation: any access is abandoned; a write already committed in its rise cycle persists.

Test Plan:
- Loader writes 0x5A3 @0x010 and 0xFFF @0xFFF, then the CPU raises `rdm` with `abus`=0x010 (READ_LATENCY=2, SYNC_STAGES=2) -> `dbus`=0x5A3 first driven exactly 2 cycles after rise detect, held until `rdm` falls, then hi-Z; the same flow at 0xFFF returns 0xFFF (top-address check).
- `wrm` pulse with `abus`=0x123, `dbus`=0x7E1, after which `dbus` changes to 0x000 while `wrm` is still high; a later read of 0x123 -> returns 0x7E1, and `busy` is high only while synchronised `wrm` is high.
- `rdm` asserted then dropped after 1 cycle of synchronised level with READ_LATENCY=4 -> `dbus` never driven, return to IDLE, `err`=0.
- `wrm` and `rdm` raised together -> `err`=1, no array change, `ld_ready`=0 until both strobes are low; `err` stays 1 until `rst`=0 clears it to 0.
- `ld_valid` held with 0x0AB @0x020 while `wrm` rises -> loader stalls (`ld_ready`=0), the bus write completes, then the loader is accepted once IDLE with both strobes low; a read of 0x020 returns 0x0AB.
- `rst` driven low during RD_DRIVE -> `dbus` hi-Z within the same cycle, `busy`=0, array contents preserved on the next read.
